// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is held low, driven high, or driven by one shared PWM waveform.
// Optional macro PWM_DUTY_SHADOW_EN makes duty changes take effect only at period boundaries.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_tick
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PIN_W   = 16;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  logic [CNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0] pwm_cnt;
  logic [CNT_W-1:0] duty_eff;
  logic             step;
  logic             pwm_sig;
  logic [PIN_W-1:0] en_out;
  logic [PIN_W-1:0] en_pwm;
  logic [PIN_W-1:0] out_nxt;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign step   = (pre_cnt == PRE_LAST);

  // Free-running prescaler and period counter; pwm_cnt wraps 255->0 on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= step ? '0 : pre_cnt + CNT_W'(1);
      if (step) begin
        pwm_cnt <= pwm_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  // Shadow duty reloads on the last step of a period so every period is whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_eff <= '0;
    end else if (step && (pwm_cnt == CNT_LAST)) begin
      duty_eff <= pwm_duty_cycle;
    end
  end
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  // Full-scale duty is forced high so 0xFF never dips for one step.
  assign pwm_sig = (duty_eff == CNT_LAST) || (pwm_cnt < duty_eff);

  assign out_nxt = (en_out & ~en_pwm) | (en_out & en_pwm & {PIN_W{pwm_sig}});

  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= '0;
      period_tick <= 1'b0;
    end else begin
      out         <= out_nxt;
      period_tick <= (pre_cnt == '0) && (pwm_cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized self-checking bench for pwm_peripheral; runs a CLK_DIV=13 and a CLK_DIV=1 instance side by side.
module tb_pwm_peripheral;

  localparam int unsigned DIV_A = 13;
  localparam int unsigned PER_A = 256 * DIV_A;
  localparam int unsigned PER_B = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out_a, out_b;
  logic        tick_a, tick_b;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] sh_a = 8'h00;
  logic [7:0] sh_b = 8'h00;
`endif

  always #50 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(DIV_A)) u_dut_a (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out_a), .period_tick(tick_a)
  );

  pwm_peripheral #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out_b), .period_tick(tick_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pin level from the rules: disabled -> 0, static -> 1, PWM -> high while step index < duty.
  function automatic logic [15:0] model_out(input int unsigned c, input int unsigned div,
                                            input logic [7:0] d, input logic [15:0] eo,
                                            input logic [15:0] ep);
    int unsigned idx;
    logic s;
    idx = (c / div) % 256;
    s = (d == 8'hFF) || (idx < int'(d));
    return (eo & ~ep) | (eo & ep & {16{s}});
  endfunction

  // Advance one clock, then compare both instances against the model.
  task automatic step_cycle();
    logic [15:0] eo, ep, e_a, e_b;
    logic [7:0]  d_a, d_b, d_in;
    logic        t_a, t_b, r;
    eo = {eo_hi, eo_lo};
    ep = {ep_hi, ep_lo};
    d_in = duty;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      e_a = 16'h0; e_b = 16'h0; t_a = 1'b0; t_b = 1'b0;
      cyc = 0;
`ifdef PWM_DUTY_SHADOW_EN
      sh_a = 8'h00; sh_b = 8'h00;
`endif
    end else begin
`ifdef PWM_DUTY_SHADOW_EN
      d_a = sh_a; d_b = sh_b;
      if (cyc % PER_A == PER_A - 1) sh_a = d_in;
      if (cyc % PER_B == PER_B - 1) sh_b = d_in;
`else
      d_a = d_in; d_b = d_in;
`endif
      e_a = model_out(cyc, DIV_A, d_a, eo, ep);
      e_b = model_out(cyc, 1, d_b, eo, ep);
      t_a = (cyc % PER_A) == 0;
      t_b = (cyc % PER_B) == 0;
      cyc++;
    end
    check("out_div13", 32'(out_a), 32'(e_a));
    check("tick_div13", 32'(tick_a), 32'(t_a));
    check("out_div1", 32'(out_b), 32'(e_b));
    check("tick_div1", 32'(tick_b), 32'(t_b));
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < int'(n); i++) step_cycle();
  endtask

  task automatic wait_tick(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!tick_a && n < budget) begin
      step_cycle();
      n++;
    end
    check("tick_seen", 32'(tick_a), 32'(1));
  endtask

  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
    duty = d;
  endtask

  initial begin
    int unsigned hi0, hi1, bad_static;
    logic [15:0] exp_restart;

    // Reset held with every input at 0xFF
    rst = 1'b1;
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    run(5);
    rst = 1'b0;
    set_regs(16'h0000, 16'h0000, 8'h00);
    step_cycle();
    check("tick_after_reset", 32'(tick_a), 32'(1));

    // Static drive for three periods
    set_regs(16'h00FF, 16'h0000, 8'h00);
    run(3 * PER_A);

    // 50% PWM on 0xA5A5: measured high time and period length
    set_regs(16'hFFFF, 16'hA5A5, 8'h80);
    run(PER_A);
    wait_tick(PER_A + 1);
    hi0 = 0;
    bad_static = 0;
    for (int j = 0; j < int'(PER_A); j++) begin
      if (out_a[0]) hi0++;
      if (!out_a[1]) bad_static++;
      step_cycle();
    end
    check("pwm50_high", hi0, 1664);
    check("static_pin_low", bad_static, 0);
    check("period_len", 32'(tick_a), 32'(1));

    // Duty extremes
    duty = 8'h00;
    run(3 * PER_A);
    duty = 8'hFF;
    run(3 * PER_A);

    // Mid-period change 0x40 -> 0xC0 when the period counter reaches 0x20
    duty = 8'h40;
    run(PER_A);
    wait_tick(PER_A + 1);
    hi0 = 0;
    hi1 = 0;
    for (int j = 0; j < int'(2 * PER_A); j++) begin
      if (out_a[0]) begin
        if (j < int'(PER_A)) hi0++;
        else hi1++;
      end
      if (j == 8'h20 * DIV_A - 1) duty = 8'hC0;
      step_cycle();
    end
`ifdef PWM_DUTY_SHADOW_EN
    check("mid_change_p0", hi0, 64 * DIV_A);
`else
    check("mid_change_p0", hi0, 192 * DIV_A);
`endif
    check("mid_change_p1", hi1, 192 * DIV_A);

    // Reset at period counter 0x90 with duty 0xC0
    for (int n = 0; n < int'(PER_A) && ((cyc / DIV_A) % 256) != 32'h90; n++) step_cycle();
    check("reached_0x90", (cyc / DIV_A) % 256, 32'h90);
    rst = 1'b1;
    step_cycle();
    check("out_in_reset", 32'(out_a), 32'(0));
    rst = 1'b0;
    step_cycle();
    check("tick_restart", 32'(tick_a), 32'(1));
`ifdef PWM_DUTY_SHADOW_EN
    exp_restart = 16'h5A5A;
`else
    exp_restart = 16'hFFFF;
`endif
    check("out_restart", 32'(out_a), 32'(exp_restart));
    run(PER_A);

    // Random register traffic with occasional reset pulses
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(63) == 0) begin
        eo_lo = 8'($urandom); eo_hi = 8'($urandom);
        ep_lo = 8'($urandom); ep_hi = 8'($urandom);
        case ($urandom_range(3))
          0: duty = 8'h00;
          1: duty = 8'hFF;
          default: duty = 8'($urandom);
        endcase
      end
      rst = ($urandom_range(1999) == 0);
      step_cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
